// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared CPU/memory command encoding, MMIO map and
// responder FSM states, imported by both the CPU side and the responder.
package mem_map_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_BAD   = 2'b11
  } mem_cmd_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } resp_state_e;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU load/store bus between a CPU and mem_responder.
// master = CPU (cmd/addr/wdata out), slave = responder (rdata/ready out).
interface mem_responder_if;
  import mem_map_pkg::*;

  mem_cmd_e    mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        ready;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, ready
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/ram256x16.sv
// ram256x16: 16-bit RAM, one write port, one synchronous read port.
// Ports: clk, we/waddr/wdata (write), re/raddr (read), rdata (held when re=0).
module ram256x16 #(
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [15:0] wdata,
  input  logic        re,
  input  logic [7:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem_q [WORDS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: RAM + LED/switch MMIO responder with post-reset RAM clear.
// Ports: clk, reset (async, low), bus (CPU slave), sw, led, prog_*, err.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int         RAM_WORDS = 256,
  parameter logic [8:0] LED_ADDR  = LED_ADDR_DEF,
  parameter logic [8:0] SW_ADDR   = SW_ADDR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  input  logic [9:0]      sw,
  output logic [7:0]      led,
  input  logic            prog_we,
  input  logic [7:0]      prog_addr,
  input  logic [15:0]     prog_data,
  output logic            err
);

  localparam logic [7:0] LAST = 8'(RAM_WORDS - 1);

  resp_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  led_q, led_d;
  logic        err_q, err_d;
  logic [15:0] mmio_q, mmio_d;
  logic        src_ram_q, src_ram_d;
  logic [9:0]  sw1_q, sw2_q;

  logic        ram_we, ram_re;
  logic [7:0]  ram_waddr;
  logic [15:0] ram_wdata, ram_rdata;

  logic is_ram, is_led, is_sw;

  assign is_ram = ~bus.mem_addr[8];
  assign is_led = bus.mem_addr == LED_ADDR;
  assign is_sw  = bus.mem_addr == SW_ADDR;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    led_d     = led_q;
    err_d     = err_q;
    mmio_d    = mmio_q;
    src_ram_d = src_ram_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = bus.mem_addr[7:0];
    ram_wdata = bus.write_data;
    unique case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == LAST) state_d = ST_READY;
      end
      ST_READY: begin
        unique case (bus.mem_cmd)
          CMD_READ: begin
            unique case (1'b1)
              is_ram: begin
                ram_re    = 1'b1;
                src_ram_d = 1'b1;
              end
              is_sw: begin
                src_ram_d = 1'b0;
                mmio_d    = {6'b0, sw2_q};
              end
              default: begin
                src_ram_d = 1'b0;
                mmio_d    = '0;
                err_d     = 1'b1;
              end
            endcase
          end
          CMD_WRITE: begin
            // program load owns the write port this cycle
            if (prog_we) begin
              err_d = 1'b1;
            end else begin
              unique case (1'b1)
                is_ram:  ram_we = 1'b1;
                is_led:  led_d  = bus.write_data[7:0];
                default: err_d  = 1'b1;
              endcase
            end
          end
          CMD_BAD:  err_d = 1'b1;
          default: ;
        endcase
        if (prog_we) begin
          ram_we    = 1'b1;
          ram_waddr = prog_addr;
          ram_wdata = prog_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      led_q     <= '0;
      err_q     <= 1'b0;
      mmio_q    <= '0;
      src_ram_q <= 1'b0;
      sw1_q     <= '0;
      sw2_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      err_q     <= err_d;
      mmio_q    <= mmio_d;
      src_ram_q <= src_ram_d;
      sw1_q     <= sw;
      sw2_q     <= sw1_q;
    end
  end

  ram256x16 #(.WORDS(RAM_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (bus.mem_addr[7:0]),
    .rdata (ram_rdata)
  );

  // RAM data comes straight from the RAM's read register
  assign bus.read_data = src_ram_q ? ram_rdata : mmio_q;
  assign bus.ready     = state_q == ST_READY;
  assign led           = led_q;
  assign err           = err_q;

endmodule
